// File: rtl/pwm_pkg.sv
// pwm_pkg: shared defaults and channel mode encoding for the PWM bank
package pwm_pkg;

    localparam int PWM_CHANNELS   = 4;
    localparam int PWM_WIDTH      = 8;
    localparam int PWM_PRESCALE_W = 4;

    typedef enum logic {
        PWM_MODE_FIXED   = 1'b0,
        PWM_MODE_BREATHE = 1'b1
    } pwm_mode_e;

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: shadow/active duty and mode, breathe stepping and output compare
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             wrap,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] count,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_duty,
    input  logic             wr_breathe,
    output logic             out
);

    logic [WIDTH-1:0] sh_duty_q, sh_duty_d;
    logic [WIDTH-1:0] act_duty_q, act_duty_d;
    pwm_mode_e        sh_mode_q, sh_mode_d;
    pwm_mode_e        act_mode_q, act_mode_d;
    logic             dir_up_q, dir_up_d;
    logic             out_q, out_d;
    logic             up_ok, dn_ok, go_up;
    logic [WIDTH-1:0] clamped, stepped;

    always_comb begin
        sh_duty_d  = wr ? wr_duty : sh_duty_q;
        sh_mode_d  = wr ? (wr_breathe ? PWM_MODE_BREATHE : PWM_MODE_FIXED) : sh_mode_q;
        up_ok      = act_duty_q < period;
        dn_ok      = act_duty_q != '0;
        go_up      = dir_up_q ? up_ok : !dn_ok;
        clamped    = act_duty_q > period ? period : act_duty_q;
        // Bounce at either end; a period lowered under the duty snaps it back to period
        stepped    = act_duty_q > period ? period :
                     go_up ? (up_ok ? act_duty_q + 1'b1 : act_duty_q) :
                             (dn_ok ? act_duty_q - 1'b1 : act_duty_q);
        act_duty_d = act_duty_q;
        act_mode_d = act_mode_q;
        dir_up_d   = dir_up_q;
        if (!enable) begin
            act_duty_d = sh_duty_q;
            act_mode_d = sh_mode_q;
        end else if (wrap) begin
            act_mode_d = sh_mode_q;
            act_duty_d = sh_mode_q == PWM_MODE_FIXED  ? sh_duty_q :
                         act_mode_q == PWM_MODE_FIXED ? clamped : stepped;
            dir_up_d   = (sh_mode_q == PWM_MODE_BREATHE && act_mode_q == PWM_MODE_BREATHE) ?
                         go_up : dir_up_q;
        end
        out_d = enable && (count < act_duty_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sh_duty_q  <= '0;
            sh_mode_q  <= PWM_MODE_FIXED;
            act_duty_q <= '0;
            act_mode_q <= PWM_MODE_FIXED;
            dir_up_q   <= 1'b1;
            out_q      <= 1'b0;
        end else begin
            sh_duty_q  <= sh_duty_d;
            sh_mode_q  <= sh_mode_d;
            act_duty_q <= act_duty_d;
            act_mode_q <= act_mode_d;
            dir_up_q   <= dir_up_d;
            out_q      <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/pwm_bank.sv
// pwm_bank: prescaled shared period counter, write decode and a bank of PWM channels
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int CHANNELS   = PWM_CHANNELS,
    parameter int WIDTH      = PWM_WIDTH,
    parameter int PRESCALE_W = PWM_PRESCALE_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [WIDTH-1:0]      period,
    input  logic                  wr_en,
    input  logic [3:0]            wr_ch,
    input  logic [WIDTH-1:0]      wr_duty,
    input  logic                  wr_breathe,
    output logic [CHANNELS-1:0]   out,
    output logic                  period_tick
);

    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [WIDTH-1:0]      cnt_q, cnt_d;
    logic                  period_tick_q, period_tick_d;
    logic                  tick, wrap;
    logic [CHANNELS-1:0]   wr_sel;

    always_comb begin
        // >= rather than == so a lowered prescale/period never runs through overflow
        tick          = enable && (presc_q >= prescale);
        wrap          = tick && (cnt_q >= period);
        presc_d       = (!enable || tick) ? '0 : presc_q + 1'b1;
        cnt_d         = (!enable || wrap) ? '0 : tick ? cnt_q + 1'b1 : cnt_q;
        period_tick_d = wrap;
        wr_sel        = '0;
        for (int i = 0; i < CHANNELS; i++) wr_sel[i] = wr_en && (wr_ch == 4'(i));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q       <= '0;
            cnt_q         <= '0;
            period_tick_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            cnt_q         <= cnt_d;
            period_tick_q <= period_tick_d;
        end
    end

    assign period_tick = period_tick_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        pwm_channel #(.WIDTH(WIDTH)) u_ch (
            .clock      (clock),
            .reset      (reset),
            .enable     (enable),
            .wrap       (wrap),
            .period     (period),
            .count      (cnt_q),
            .wr         (wr_sel[c]),
            .wr_duty    (wr_duty),
            .wr_breathe (wr_breathe),
            .out        (out[c])
        );
    end

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: directed checks of the PWM bank with immediate assertions
module tb_pwm_bank;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] prescale;
    logic [7:0] period;
    logic       wr_en;
    logic [3:0] wr_ch;
    logic [7:0] wr_duty;
    logic       wr_breathe;
    logic [3:0] out;
    logic       period_tick;

    int vecs = 0;
    int miss = 0;

    pwm_bank dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .prescale    (prescale),
        .period      (period),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_duty     (wr_duty),
        .wr_breathe  (wr_breathe),
        .out         (out),
        .period_tick (period_tick)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [3:0] ch, input logic [7:0] duty, input logic br);
        wr_en = 1'b1; wr_ch = ch; wr_duty = duty; wr_breathe = br;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        logic [7:0] d0;
        logic [7:0] bd [8];
        bd = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0, 8'd1};
        reset = 1'b1; enable = 1'b0; prescale = '0; period = 8'd9;
        wr_en = 1'b0; wr_ch = '0; wr_duty = '0; wr_breathe = 1'b0;
        step(); step();
        chk("reset_out", 32'(out), 32'h0);
        chk("reset_tick", 32'(period_tick), 32'h0);
        chk("reset_cnt", 32'(dut.cnt_q), 32'h0);
        reset = 1'b0;

        // duty 3 on ch0, 0 on ch1, 10 (> period) on ch2, written while disabled
        write(4'd0, 8'd3, 1'b0);
        write(4'd1, 8'd0, 1'b0);
        write(4'd2, 8'd10, 1'b0);
        step();
        chk("disabled_out", 32'(out), 32'h0);
        chk("disabled_cnt", 32'(dut.cnt_q), 32'h0);
        enable = 1'b1;
        // mid-cycle write of 7, invalid channel 15, and a write on the wrap edge at k=30
        for (int k = 1; k <= 50; k++) begin
            wr_en   = (k == 16 || k == 17 || k == 30);
            wr_ch   = k == 17 ? 4'd15 : 4'd0;
            wr_duty = k == 16 ? 8'd7 : k == 17 ? 8'd9 : 8'd2;
            step();
            d0 = k <= 20 ? 8'd3 : k <= 40 ? 8'd7 : 8'd2;
            chk($sformatf("run_out k=%0d", k), 32'(out), 32'({1'b0, 1'b1, 1'b0, 8'((k - 1) % 10) < d0}));
            chk($sformatf("run_tick k=%0d", k), 32'(period_tick), 32'(k % 10 == 0));
            chk($sformatf("run_cnt k=%0d", k), 32'(dut.cnt_q), 32'(k % 10));
        end
        wr_en = 1'b0;

        // prescale 3: counter steps every 4 clocks
        enable = 1'b0;
        step();
        chk("stop_out", 32'(out), 32'h0);
        chk("stop_tick", 32'(period_tick), 32'h0);
        chk("stop_cnt", 32'(dut.cnt_q), 32'h0);
        prescale = 4'd3;
        enable = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            step();
            chk($sformatf("pre_cnt k=%0d", k), 32'(dut.cnt_q), 32'((k / 4) % 10));
            chk($sformatf("pre_tick k=%0d", k), 32'(period_tick), 32'(k % 40 == 0));
            chk($sformatf("pre_out k=%0d", k), 32'(out), 32'({1'b0, 1'b1, 1'b0, ((k - 1) / 4) % 10 < 2}));
        end

        // breathe on ch3 with period 3
        enable = 1'b0;
        prescale = 4'd0;
        period = 8'd3;
        write(4'd3, 8'd0, 1'b1);
        step();
        enable = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            chk($sformatf("br_out k=%0d", k), 32'(out),
                32'({8'((k - 1) % 4) < bd[(k - 1) / 4], 1'b1, 1'b0, (k - 1) % 4 < 2}));
            chk($sformatf("br_tick k=%0d", k), 32'(period_tick), 32'(k % 4 == 0));
        end

        // reset mid-cycle, overriding enable and a pending write
        step(); step();
        reset = 1'b1;
        wr_en = 1'b1; wr_ch = 4'd0; wr_duty = 8'd5; wr_breathe = 1'b0;
        step();
        reset = 1'b0;
        wr_en = 1'b0;
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_tick", 32'(period_tick), 32'h0);
        chk("rst_cnt", 32'(dut.cnt_q), 32'h0);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("post_out k=%0d", k), 32'(out), 32'h0);
            chk($sformatf("post_cnt k=%0d", k), 32'(dut.cnt_q), 32'(k % 4));
            chk($sformatf("post_tick k=%0d", k), 32'(period_tick), 32'(k % 4 == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent PWM outputs (1..16).
REQ-002 Parameter WIDTH, default 8: width of the period counter, period and duty values.
REQ-003 Parameter PRESCALE_W, default 4: width of the clock prescaler setting.
REQ-004 Port clock  input  1: single clock; all logic SHALL be on its rising edge.
REQ-005 Port reset  input  1: synchronous, active-high reset.
REQ-006 Port enable  input  1: run control; low = counters held at 0 and outputs low.
REQ-007 Port prescale  input  PRESCALE_W: counter advances once every prescale+1 clocks.
REQ-008 Port period  input  WIDTH: counter runs 0..period, giving period+1 steps per PWM cycle.
REQ-009 Port wr_en  input  1: one-cycle write strobe for channel configuration.
REQ-010 Port wr_ch  input  4: channel index for the write.
REQ-011 Port wr_duty  input  WIDTH: duty value to write.
REQ-012 Port wr_breathe  input  1: mode to write; 0 = fixed duty, 1 = breathe.
REQ-013 Port out  output  CHANNELS: registered PWM outputs.
REQ-014 Port period_tick  output  1: one-clock pulse on each counter wrap.

Function
REQ-015 Prescaler SHALL count 0..prescale and assert an internal tick when it equals prescale; prescale=0 gives a tick every clock.
REQ-016 On each tick the counter SHALL increment; when counter >= period on a tick it SHALL wrap to 0, and period_tick SHALL pulse in the following clock.
REQ-017 A period lowered below the current count SHALL cause a wrap on the next tick; there SHALL be no overflow run-through.
REQ-018 Each channel SHALL hold a shadow (duty, mode) and an active (duty, mode); writes SHALL update only the shadow.
REQ-019 Active SHALL load from shadow on every wrap, and continuously while enable=0.
REQ-020 A write in the same clock as a wrap SHALL land in the shadow only; active SHALL take the previous shadow, and the new value SHALL apply at the following wrap.
REQ-021 A write with wr_ch >= CHANNELS SHALL be ignored.
REQ-022 out[i] SHALL be registered as enable && (counter < active_duty[i]), with 1-clock latency from the counter.
REQ-023 Duty 0 SHALL give constant low; duty > period SHALL give constant high.
REQ-024 In breathe mode, on each wrap active duty SHALL step by 1 toward period (direction up) or toward 0 (direction down), ignoring the shadow duty.
REQ-025 In breathe mode, direction SHALL reverse when duty reaches period or 0.
REQ-026 If the active duty exceeds period when breathe mode is entered, it SHALL clamp to period.
REQ-027 When enable is low, prescaler, counter, out and period_tick SHALL be 0, while shadow writes SHALL still be accepted.

Reset
REQ-028 Reset SHALL clear prescaler, counter, all shadow and active duties and modes, out and period_tick to 0, and set every breathe direction to up.
REQ-029 Reset asserted mid-cycle SHALL take effect at the next clock edge and SHALL override enable and wr_en.

Structure
REQ-030 Package pwm_pkg SHALL hold the default CHANNELS, WIDTH and PRESCALE_W constants and the mode enum (PWM_MODE_FIXED, PWM_MODE_BREATHE).
REQ-031 Per-channel shadow, active, breathe and compare logic SHALL live in sub-module pwm_channel, generated CHANNELS times.
REQ-032 Prescaler, counter and write decode SHALL be in the pwm_bank top.

Verification
REQ-033 Config prescale=0, period=9; write ch0 duty 3 with enable=0, then set enable=1 -> out[0] high 3 of every 10 clocks, and period_tick every 10 clocks.
REQ-034 Config period=9; write ch1 duty 0 and ch2 duty 10 -> out[1] constant 0 and out[2] constant 1 after the first wrap.
REQ-035 While running ch0 at duty 3, write duty 7 mid-cycle -> 3/10 is kept until the next period_tick, then 7/10; a write to wr_ch=15 changes nothing.
REQ-036 Config prescale=3, period=9 -> the counter steps every 4 clocks and period_tick occurs every 40 clocks.
REQ-037 Config period=3 with ch3 in breathe mode -> active duty per successive cycle is 1,2,3,2,1,0,1.
REQ-038 Assert reset for 1 clock mid-cycle with wr_en high -> out=0, period_tick=0, counter=0 and all duties 0 on the next clock.
